// File: rtl/tone_decoder.sv
// Square-wave tone receiver: measures rising-to-rising period and
// classifies it against the octave-5 note table with debounce.
module tone_decoder #(
    parameter int unsigned clk_100Mhz  = 100_000_000,
    parameter int unsigned TOL_SHIFT   = 5,
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned SILENCE_CYC = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [2:0]  note_code,
    output logic        note_valid,
    output logic        note_off,
    output logic        tone_active,
    output logic [23:0] period_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_TRACK
    } state_t;

    localparam logic [23:0] SIL = 24'(SILENCE_CYC);
    localparam logic [7:0]  STB = 8'(STABLE_CNT);

    localparam logic [23:0] P_TBL [7] = '{
        24'(clk_100Mhz / 523),
        24'(clk_100Mhz / 587),
        24'(clk_100Mhz / 659),
        24'(clk_100Mhz / 698),
        24'(clk_100Mhz / 783),
        24'(clk_100Mhz / 880),
        24'(clk_100Mhz / 988)
    };

    state_t      r_state;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [23:0] r_cnt;
    logic        r_cls_vld;
    logic [2:0]  r_cls;
    logic [2:0]  r_cand;
    logic [7:0]  r_match;

    logic        w_edge;
    logic        w_busy;
    logic        w_tmo;
    logic        w_cap;
    logic [2:0]  w_cls;
    logic [7:0]  w_match_nx;

    function automatic logic hit(
        input logic [23:0] m,
        input logic [23:0] p
    );
        logic [23:0] d;
        d = (m >= p) ? m - p : p - m;
        return d <= (p >> TOL_SHIFT);
    endfunction

    assign w_edge = r_s2 & ~r_s3;
    assign w_busy = (r_state != S_IDLE);
    assign w_tmo  = w_busy && (r_cnt == SIL);
    assign w_cap  = w_edge && w_busy && !w_tmo;

    // Scan backwards so the lowest-index match wins on overlap.
    always_comb begin
        w_cls = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (hit(r_cnt, P_TBL[i])) begin
                w_cls = 3'(i + 1);
            end
        end
    end

    always_comb begin
        w_match_nx = 8'd1;
        if (r_cls == r_cand) begin
            w_match_nx = (r_match >= STB) ? STB : r_match + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_cnt       <= '0;
            r_cls_vld   <= 1'b0;
            r_cls       <= '0;
            r_cand      <= '0;
            r_match     <= '0;
            note_code   <= '0;
            note_valid  <= 1'b0;
            note_off    <= 1'b0;
            tone_active <= 1'b0;
            period_q    <= '0;
        end else begin
            r_s1       <= tone_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            note_valid <= 1'b0;
            note_off   <= 1'b0;
            r_cls_vld  <= w_cap;

            if (w_edge) begin
                r_cnt <= 24'd1;
            end else if (r_cnt != SIL) begin
                r_cnt <= r_cnt + 24'd1;
            end

            if (w_cap) begin
                period_q <= r_cnt;
                r_cls    <= w_cls;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_edge) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_tmo) begin
                        r_state <= w_edge ? S_ARMED : S_IDLE;
                    end else if (w_edge) begin
                        r_state     <= S_TRACK;
                        tone_active <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (w_tmo) begin
                        r_state  <= w_edge ? S_ARMED : S_IDLE;
                        note_off <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_tmo) begin
                note_code   <= '0;
                tone_active <= 1'b0;
                r_cand      <= '0;
                r_match     <= '0;
                r_cls_vld   <= 1'b0;
            end else if (r_cls_vld) begin
                r_cand  <= r_cls;
                r_match <= w_match_nx;
                if (w_match_nx == STB && r_cls != note_code) begin
                    note_code  <= r_cls;
                    note_valid <= (r_cls != 3'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder with a scaled clock so the
// note periods stay in the hundreds of cycles.
module tb_tone_decoder;

    localparam int CLK_HZ = 500_000;
    localparam int SIL    = 3000;
    // Table at 500 kHz: 956 851 758 716 638 568 506
    localparam int T_SOL  = 638;
    localparam int T_LA   = 568;
    localparam int T_OFF  = 1100;

    typedef struct {
        bit is_off;
        int code;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tone_in;
    logic [2:0]  note_code;
    logic        note_valid;
    logic        note_off;
    logic        tone_active;
    logic [23:0] period_q;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_rise = 0;
    ev_t  q[$];

    tone_decoder #(
        .clk_100Mhz (CLK_HZ),
        .TOL_SHIFT  (5),
        .STABLE_CNT (3),
        .SILENCE_CYC(SIL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tone_in    (tone_in),
        .note_code  (note_code),
        .note_valid (note_valid),
        .note_off   (note_off),
        .tone_active(tone_active),
        .period_q   (period_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic push(input bit off, input int code, input int c);
        ev_t e;
        e.is_off = off;
        e.code   = code;
        e.cyc    = c;
        q.push_back(e);
    endtask

    task automatic wave(input int h, input int l);
        tone_in   = 1'b1;
        last_rise = cyc;
        repeat (h) @(negedge clk);
        tone_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic waves(input int t, input int n);
        for (int i = 0; i < n; i++) wave(t / 2, t - t / 2);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_code"}, int'(note_code), 0);
        chk({nm, "_act"}, int'(tone_active), 0);
        chk({nm, "_per"}, int'(period_q), 0);
        chk({nm, "_pulse"}, int'(note_valid | note_off), 0);
    endtask

    // Monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (note_valid && note_off) begin
            checks++;
            errors++;
            $display("FAIL both_pulses at cyc %0d", cyc);
        end else if (note_valid || note_off) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%0b off=%0b cyc %0d",
                         note_valid, note_off, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.is_off != note_off) begin
                    errors++;
                    $display("FAIL pulse_kind got off=%0b exp off=%0b",
                             note_off, e.is_off);
                end else if (!e.is_off && int'(note_code) != e.code) begin
                    errors++;
                    $display("FAIL valid_code got %0d exp %0d",
                             note_code, e.code);
                end else if (e.is_off && int'(note_code) != 0) begin
                    errors++;
                    $display("FAIL off_code got %0d exp 0", note_code);
                end else if (e.cyc >= 0 && cyc != e.cyc) begin
                    errors++;
                    $display("FAIL off_cycle got %0d exp %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_zero("rst");
        repeat (3500) @(negedge clk);
        chk_zero("quiet");

        // Sol lock
        push(1'b0, 5, -1);
        waves(T_SOL, 6);
        chk("sol_code", int'(note_code), 5);
        chk("sol_act", int'(tone_active), 1);
        chk("sol_per", int'(period_q), T_SOL);

        // La: first La rise still measures a Sol period
        push(1'b0, 6, -1);
        waves(T_LA, 3);
        chk("la_hold", int'(note_code), 5);
        waves(T_LA, 1);
        chk("la_code", int'(note_code), 6);
        chk("la_per", int'(period_q), T_LA);
        for (int i = 0; i < 3; i++) begin
            wave(283, 284);
            wave(284, 285);
        end
        chk("la_jit", int'(note_code), 6);

        // Silence timeout
        push(1'b1, 0, last_rise + SIL + 3);
        repeat (SIL + 100) @(negedge clk);
        chk("off_code", int'(note_code), 0);
        chk("off_act", int'(tone_active), 0);
        chk("off_per", int'(period_q), 567);

        // Off-table after Sol
        push(1'b0, 5, -1);
        waves(T_SOL, 5);
        chk("sol2_code", int'(note_code), 5);
        waves(T_OFF, 3);
        chk("unk_hold", int'(note_code), 5);
        waves(T_OFF, 2);
        chk("unk_code", int'(note_code), 0);
        chk("unk_act", int'(tone_active), 1);
        chk("unk_per", int'(period_q), T_OFF);

        // Reset mid-tracking, while the pin is low
        push(1'b0, 5, -1);
        waves(T_SOL, 5);
        tone_in   = 1'b1;
        last_rise = cyc;
        repeat (319) @(negedge clk);
        tone_in = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst", int'(note_code), 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("mid_rst");
        repeat (219) @(negedge clk);
        push(1'b0, 5, -1);
        waves(T_SOL, 5);
        chk("relock", int'(note_code), 5);

        // Edge landing on the timeout cycle: timeout wins, re-arms
        wave(319, SIL - 319);
        push(1'b1, 0, last_rise + SIL + 3);
        push(1'b0, 5, -1);
        waves(T_SOL, 1);
        chk("rearm_act", int'(tone_active), 0);
        chk("rearm_per", int'(period_q), T_SOL);
        chk("rearm_code", int'(note_code), 0);
        waves(T_SOL, 3);
        chk("rearm_lock", int'(note_code), 5);
        push(1'b1, 0, last_rise + SIL + 3);

        for (int i = 0; i < SIL + 200 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
